iiitb_sd_serializer: RTL and testbench



---
 rtl/iiitb_sd_serializer.sv | 139 +++++++++++++
 tb/tb_iiitb_sd_serializer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/iiitb_sd_serializer.sv
// Parallel-to-serial front end for the iiitb_sd sequence detector.
// A one-word holding buffer lets consecutive words stream with no idle bit between frames.
module iiitb_sd_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shifter_q, shifter_d;
  logic [WIDTH-1:0] bufWord_q, bufWord_d;
  logic             bufFull_q, bufFull_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             doutValid_q, doutValid_d;
  logic             frameStart_q, frameStart_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             accept;

  function automatic logic firstBit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // dout is registered, so the bit after the one currently shown sits one place in from the output end
  function automatic logic nextBit(input logic [WIDTH-1:0] s);
    return MSB_FIRST ? s[WIDTH-2] : s[1];
  endfunction

  function automatic logic [WIDTH-1:0] shiftOnce(input logic [WIDTH-1:0] s);
    return MSB_FIRST ? (s << 1) : (s >> 1);
  endfunction

  assign accept = data_valid && ready_q;

  always_comb begin
    state_d      = state_q;
    shifter_d    = shifter_q;
    bufWord_d    = bufWord_q;
    bufFull_d    = bufFull_q;
    cnt_d        = cnt_q;
    dout_d       = dout_q;
    doutValid_d  = doutValid_q;
    frameStart_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        dout_d      = IDLE_BIT;
        doutValid_d = 1'b0;
        if (accept) begin
          state_d      = SHIFT;
          shifter_d    = data_in;
          dout_d       = firstBit(data_in);
          doutValid_d  = 1'b1;
          frameStart_d = 1'b1;
          cnt_d        = '0;
        end
      end
      SHIFT: begin
        if (cnt_q != LAST) begin
          shifter_d = shiftOnce(shifter_q);
          dout_d    = nextBit(shifter_q);
          cnt_d     = cnt_q + 1'b1;
          if (accept) begin
            bufWord_d = data_in;
            bufFull_d = 1'b1;
          end
        end else if (bufFull_q) begin
          shifter_d    = bufWord_q;
          dout_d       = firstBit(bufWord_q);
          frameStart_d = 1'b1;
          cnt_d        = '0;
          bufFull_d    = 1'b0;
        end else if (accept) begin
          shifter_d    = data_in;
          dout_d       = firstBit(data_in);
          frameStart_d = 1'b1;
          cnt_d        = '0;
        end else begin
          state_d     = IDLE;
          dout_d      = IDLE_BIT;
          doutValid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = !bufFull_d;
    busy_d  = (state_d == SHIFT) || bufFull_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      shifter_q    <= '0;
      bufWord_q    <= '0;
      bufFull_q    <= 1'b0;
      cnt_q        <= '0;
      dout_q       <= IDLE_BIT;
      doutValid_q  <= 1'b0;
      frameStart_q <= 1'b0;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shifter_q    <= shifter_d;
      bufWord_q    <= bufWord_d;
      bufFull_q    <= bufFull_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      doutValid_q  <= doutValid_d;
      frameStart_q <= frameStart_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
    end
  end

  assign data_ready  = ready_q;
  assign dout        = dout_q;
  assign dout_valid  = doutValid_q;
  assign frame_start = frameStart_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_iiitb_sd_serializer.sv
// Directed bench for iiitb_sd_serializer: MSB-first and LSB-first instances,
// plus a 1011 Moore detector hung off the MSB-first stream.
module tb_iiitb_sd_serializer;

  logic       clk;
  logic       reset;
  logic [7:0] dataInM, dataInL;
  logic       validM, validL;
  logic       readyM, readyL;
  logic       doutM, doutL;
  logic       dvM, dvL;
  logic       fsM, fsL;
  logic       busyM, busyL;

  int checkCount;
  int passCount;

  iiitb_sd_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) uMsb (
    .clk(clk), .reset(reset), .data_in(dataInM), .data_valid(validM),
    .data_ready(readyM), .dout(doutM), .dout_valid(dvM),
    .frame_start(fsM), .busy(busyM)
  );

  iiitb_sd_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) uLsb (
    .clk(clk), .reset(reset), .data_in(dataInL), .data_valid(validL),
    .data_ready(readyL), .dout(doutL), .dout_valid(dvL),
    .frame_start(fsL), .busy(busyL)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Overlapping 1011 Moore detector fed by the MSB-first serial stream
  typedef enum logic [2:0] {D0, D1, D2, D3, D4} detState_t;
  detState_t detQ;
  logic      detY;

  always_ff @(posedge clk) begin
    if (reset) detQ <= D0;
    else begin
      case (detQ)
        D0:      detQ <= doutM ? D1 : D0;
        D1:      detQ <= doutM ? D1 : D2;
        D2:      detQ <= doutM ? D3 : D0;
        D3:      detQ <= doutM ? D4 : D2;
        D4:      detQ <= doutM ? D1 : D2;
        default: detQ <= D0;
      endcase
    end
  end
  assign detY = (detQ == D4);

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkCount++;
    if ({readyM, busyM, doutM, dvM, fsM} !== 5'b10000)
      $display("[TB] FAIL reset_msb: got %b expected %b", {readyM, busyM, doutM, dvM, fsM}, 5'b10000);
    else passCount++;
    checkCount++;
    if ({readyL, busyL, doutL, dvL, fsL} !== 5'b10000)
      $display("[TB] FAIL reset_lsb: got %b expected %b", {readyL, busyL, doutL, dvL, fsL}, 5'b10000);
    else passCount++;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_msb_frame();
    logic [7:0] seq;
    logic [3:0] e;
    seq = 8'b10110101;
    dataInM = 8'hB5; validM = 1'b1;
    @(posedge clk); #1;
    validM = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      e = (k <= 8) ? {seq[8-k], 1'b1, (k == 1), 1'b1} : 4'b0000;
      checkCount++;
      if ({doutM, dvM, fsM, busyM} !== e)
        $display("[TB] FAIL msb_frame c%0d {dout,dv,fs,busy}: got %b expected %b", k, {doutM, dvM, fsM, busyM}, e);
      else passCount++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lsb_frame();
    logic [7:0] seq;
    logic [3:0] e;
    seq = 8'b10101101;
    dataInL = 8'hB5; validL = 1'b1;
    @(posedge clk); #1;
    validL = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      e = (k <= 8) ? {seq[8-k], 1'b1, (k == 1), 1'b1} : 4'b0000;
      checkCount++;
      if ({doutL, dvL, fsL, busyL} !== e)
        $display("[TB] FAIL lsb_frame c%0d {dout,dv,fs,busy}: got %b expected %b", k, {doutL, dvL, fsL, busyL}, e);
      else passCount++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] seq;
    logic [3:0]  e;
    seq = 16'b1011010100111100;
    dataInM = 8'hB5; validM = 1'b1;
    @(posedge clk); #1;
    dataInM = 8'h3C;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      e = (k <= 16) ? {seq[16-k], 1'b1, (k == 1 || k == 9), !(k >= 2 && k <= 8)} : 4'b0001;
      checkCount++;
      if ({doutM, dvM, fsM, readyM} !== e)
        $display("[TB] FAIL back_to_back c%0d {dout,dv,fs,ready}: got %b expected %b", k, {doutM, dvM, fsM, readyM}, e);
      else passCount++;
      @(posedge clk); #1;
      if (k == 1) validM = 1'b0;
    end
  endtask

  task automatic test_bypass();
    logic [15:0] seq;
    logic [2:0]  e;
    seq = 16'b1111000000001111;
    dataInM = 8'hF0; validM = 1'b1;
    @(posedge clk); #1;
    validM = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      e = (k <= 16) ? {seq[16-k], 1'b1, (k == 1 || k == 9)} : 3'b000;
      checkCount++;
      if ({doutM, dvM, fsM} !== e)
        $display("[TB] FAIL bypass c%0d {dout,dv,fs}: got %b expected %b", k, {doutM, dvM, fsM}, e);
      else passCount++;
      @(posedge clk); #1;
      if (k == 7) begin
        validM  = 1'b1;
        dataInM = 8'h0F;
      end else validM = 1'b0;
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] seq;
    logic [2:0] e;
    dataInM = 8'hFF; validM = 1'b1;
    @(posedge clk); #1;
    validM = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checkCount++;
      if ({doutM, dvM} !== 2'b11)
        $display("[TB] FAIL mid_reset_pre c%0d {dout,dv}: got %b expected %b", k, {doutM, dvM}, 2'b11);
      else passCount++;
      @(posedge clk); #1;
      if (k == 2) reset = 1'b1;
    end
    reset = 1'b0;
    @(negedge clk);
    checkCount++;
    if ({doutM, dvM, fsM, readyM, busyM} !== 5'b00010)
      $display("[TB] FAIL mid_reset_post {dout,dv,fs,ready,busy}: got %b expected %b", {doutM, dvM, fsM, readyM, busyM}, 5'b00010);
    else passCount++;
    @(posedge clk); #1;
    seq = 8'b00000001;
    dataInM = 8'h01; validM = 1'b1;
    @(posedge clk); #1;
    validM = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      e = (k <= 8) ? {seq[8-k], 1'b1, (k == 1)} : 3'b000;
      checkCount++;
      if ({doutM, dvM, fsM} !== e)
        $display("[TB] FAIL mid_reset_next c%0d {dout,dv,fs}: got %b expected %b", k, {doutM, dvM, fsM}, e);
      else passCount++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_detector_e2e();
    logic [15:0] seq;
    logic [3:0]  goldHist;
    logic        goldY;
    seq = {8'hB5, 8'h5A};
    goldHist = 4'b0000;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    dataInM = 8'hB5; validM = 1'b1;
    @(posedge clk); #1;
    dataInM = 8'h5A;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k <= 16) begin
        checkCount++;
        if ({doutM, dvM} !== {seq[16-k], 1'b1})
          $display("[TB] FAIL e2e_stream c%0d {dout,dv}: got %b expected %b", k, {doutM, dvM}, {seq[16-k], 1'b1});
        else passCount++;
      end
      goldY = (goldHist == 4'b1011);
      checkCount++;
      if (detY !== goldY)
        $display("[TB] FAIL e2e_detector c%0d y: got %b expected %b", k, detY, goldY);
      else passCount++;
      goldHist = {goldHist[2:0], (k <= 16) ? seq[16-k] : 1'b0};
      @(posedge clk); #1;
      if (k == 1) validM = 1'b0;
    end
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    reset   = 1'b1;
    dataInM = 8'h00; validM = 1'b0;
    dataInL = 8'h00; validL = 1'b0;
    test_reset();
    test_msb_frame();
    test_lsb_frame();
    test_back_to_back();
    test_bypass();
    test_reset_mid_frame();
    test_detector_e2e();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
